// File: rtl/axi4_mst_bridge_pkg.sv
// Shared bus configuration, AXI4 channel bundles and bridge FSM encoding.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
// Contents: sysbus widths, vendor ID, AXI burst/response codes, master in/out
// channel structs, device descriptor, bridge state enum, 4 KB crossing helper.
package axi4_mst_bridge_pkg;

   localparam int CFG_SYSBUS_ADDR_BITS       = 32;
   localparam int CFG_SYSBUS_DATA_BITS       = 64;
   localparam int CFG_SYSBUS_DATA_BYTES      = CFG_SYSBUS_DATA_BITS / 8;
   localparam int CFG_LOG2_SYSBUS_DATA_BYTES = 3;
   localparam int CFG_SYSBUS_ID_BITS         = 4;

   localparam logic [15:0] VENDOR_OPTIMITECH = 16'h00F1;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef struct packed {
      logic [15:0] vid;
      logic [15:0] did;
   } dev_config_type;

   // Slave-to-master channels
   typedef struct packed {
      logic                              aw_ready;
      logic                              w_ready;
      logic                              b_valid;
      logic [1:0]                        b_resp;
      logic                              ar_ready;
      logic                              r_valid;
      logic [CFG_SYSBUS_DATA_BITS-1:0]   r_data;
      logic [1:0]                        r_resp;
      logic                              r_last;
   } axi4_master_in_type;

   // Master-to-slave channels
   typedef struct packed {
      logic                              aw_valid;
      logic [CFG_SYSBUS_ADDR_BITS-1:0]   aw_addr;
      logic [7:0]                        aw_len;
      logic [2:0]                        aw_size;
      logic [1:0]                        aw_burst;
      logic [CFG_SYSBUS_ID_BITS-1:0]     aw_id;
      logic                              w_valid;
      logic [CFG_SYSBUS_DATA_BITS-1:0]   w_data;
      logic [CFG_SYSBUS_DATA_BYTES-1:0]  w_strb;
      logic                              w_last;
      logic                              b_ready;
      logic                              ar_valid;
      logic [CFG_SYSBUS_ADDR_BITS-1:0]   ar_addr;
      logic [7:0]                        ar_len;
      logic [2:0]                        ar_size;
      logic [1:0]                        ar_burst;
      logic [CFG_SYSBUS_ID_BITS-1:0]     ar_id;
      logic                              r_ready;
   } axi4_master_out_type;

   // ST_DRAIN_W / ST_ERR_B / ST_ERR_R are only reachable when the 4 KB
   // crossing check is compiled in.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW,
      ST_W,
      ST_B,
      ST_DRAIN_W,
      ST_ERR_B,
      ST_ERR_R
   } bridge_state_t;

   // True when a burst of len+1 full-width beats starting at the given page
   // offset runs past the end of its 4 KB page.
   function automatic logic crosses_4k(input logic [11:0] offs, input logic [7:0] len);
      logic [13:0] end_offs;
      end_offs = {2'b00, offs} + (({6'd0, len} + 14'd1) << CFG_LOG2_SYSBUS_DATA_BYTES);
      return end_offs > 14'd4096;
   endfunction

endpackage

// File: rtl/axi4_mst_bridge.sv
// Single-outstanding AXI4 INCR burst initiator fed by a request/stream port.
// Latency: request accept -> AR/AW valid next cycle; R/W/B paths combinational.
// Backpressure: i_resp_ready drives rready/bready, slave wready drives o_wready.
// Ports: i_clk, i_nrst (async active-low), o_cfg (vid/did), i_xmsti/o_xmsto
// (AXI4 channels), i_req_* (request), i_w* (write beats), o_resp_* (responses).
// Build option AXI4_MST_BRIDGE_4K_CHECK_EN: requests crossing a 4 KB page are
// answered locally with error responses instead of reaching the bus.
module axi4_mst_bridge
   import axi4_mst_bridge_pkg::*;
#(
   parameter logic [15:0] vid = VENDOR_OPTIMITECH,
   parameter logic [15:0] did = 16'h0000
) (
   input  logic                              i_clk,
   input  logic                              i_nrst,
   output dev_config_type                    o_cfg,
   input  axi4_master_in_type                i_xmsti,
   output axi4_master_out_type               o_xmsto,
   input  logic                              i_req_valid,
   output logic                              o_req_ready,
   input  logic                              i_req_write,
   input  logic [CFG_SYSBUS_ADDR_BITS-1:0]   i_req_addr,
   input  logic [7:0]                        i_req_len,
   input  logic                              i_wvalid,
   output logic                              o_wready,
   input  logic [CFG_SYSBUS_DATA_BITS-1:0]   i_wdata,
   input  logic [CFG_SYSBUS_DATA_BYTES-1:0]  i_wstrb,
   output logic                              o_resp_valid,
   input  logic                              i_resp_ready,
   output logic [CFG_SYSBUS_DATA_BITS-1:0]   o_resp_rdata,
   output logic                              o_resp_last,
   output logic                              o_resp_err
);

   bridge_state_t                    state, state_nxt;
   logic [CFG_SYSBUS_ADDR_BITS-1:0]  addr_q, addr_nxt;
   logic [7:0]                       len_q, len_nxt;
   logic [7:0]                       cnt_q, cnt_nxt;
   axi4_master_out_type              xmsto;

   // Only bit 1 of each response distinguishes OKAY/EXOKAY from errors.
   logic unused_resp_lsb;
   assign unused_resp_lsb = i_xmsti.r_resp[0] ^ i_xmsti.b_resp[0];

   assign o_cfg.vid = vid;
   assign o_cfg.did = did;
   assign o_xmsto   = xmsto;

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state  <= ST_IDLE;
         addr_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
      end else begin
         state  <= state_nxt;
         addr_q <= addr_nxt;
         len_q  <= len_nxt;
         cnt_q  <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      addr_nxt     = addr_q;
      len_nxt      = len_q;
      cnt_nxt      = cnt_q;
      o_req_ready  = 1'b0;
      o_wready     = 1'b0;
      o_resp_valid = 1'b0;
      o_resp_rdata = '0;
      o_resp_last  = 1'b0;
      o_resp_err   = 1'b0;

      // Address/control come straight from registers so they stay stable
      // for the whole valid-before-ready window.
      xmsto          = '0;
      xmsto.ar_addr  = addr_q;
      xmsto.ar_len   = len_q;
      xmsto.ar_size  = 3'(CFG_LOG2_SYSBUS_DATA_BYTES);
      xmsto.ar_burst = AXI_BURST_INCR;
      xmsto.aw_addr  = addr_q;
      xmsto.aw_len   = len_q;
      xmsto.aw_size  = 3'(CFG_LOG2_SYSBUS_DATA_BYTES);
      xmsto.aw_burst = AXI_BURST_INCR;

      case (state)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            if (i_req_valid) begin
               addr_nxt  = i_req_addr;
               len_nxt   = i_req_len;
               cnt_nxt   = '0;
               state_nxt = i_req_write ? ST_AW : ST_AR;
`ifdef AXI4_MST_BRIDGE_4K_CHECK_EN
               if (crosses_4k(i_req_addr[11:0], i_req_len)) begin
                  state_nxt = i_req_write ? ST_DRAIN_W : ST_ERR_R;
               end
`endif
            end
         end

         ST_AR: begin
            xmsto.ar_valid = 1'b1;
            if (i_xmsti.ar_ready) state_nxt = ST_R;
         end

         // rlast alone ends the burst, even if it disagrees with len.
         ST_R: begin
            xmsto.r_ready = i_resp_ready;
            o_resp_valid  = i_xmsti.r_valid;
            o_resp_rdata  = i_xmsti.r_data;
            o_resp_last   = i_xmsti.r_last;
            o_resp_err    = i_xmsti.r_resp[1];
            if (i_xmsti.r_valid && i_resp_ready && i_xmsti.r_last) state_nxt = ST_IDLE;
         end

         ST_AW: begin
            xmsto.aw_valid = 1'b1;
            if (i_xmsti.aw_ready) begin
               cnt_nxt   = '0;
               state_nxt = ST_W;
            end
         end

         ST_W: begin
            xmsto.w_valid = i_wvalid;
            xmsto.w_data  = i_wdata;
            xmsto.w_strb  = i_wstrb;
            xmsto.w_last  = (cnt_q == len_q);
            o_wready      = i_xmsti.w_ready;
            if (i_wvalid && i_xmsti.w_ready) begin
               cnt_nxt = cnt_q + 8'd1;
               if (cnt_q == len_q) state_nxt = ST_B;
            end
         end

         ST_B: begin
            xmsto.b_ready = i_resp_ready;
            o_resp_valid  = i_xmsti.b_valid;
            o_resp_last   = 1'b1;
            o_resp_err    = i_xmsti.b_resp[1];
            if (i_xmsti.b_valid && i_resp_ready) state_nxt = ST_IDLE;
         end

`ifdef AXI4_MST_BRIDGE_4K_CHECK_EN
         // Swallow the caller's write beats so its stream stays in sync.
         ST_DRAIN_W: begin
            o_wready = 1'b1;
            if (i_wvalid) begin
               cnt_nxt = cnt_q + 8'd1;
               if (cnt_q == len_q) state_nxt = ST_ERR_B;
            end
         end

         ST_ERR_B: begin
            o_resp_valid = 1'b1;
            o_resp_last  = 1'b1;
            o_resp_err   = 1'b1;
            if (i_resp_ready) state_nxt = ST_IDLE;
         end

         ST_ERR_R: begin
            o_resp_valid = 1'b1;
            o_resp_err   = 1'b1;
            o_resp_last  = (cnt_q == len_q);
            if (i_resp_ready) begin
               cnt_nxt = cnt_q + 8'd1;
               if (cnt_q == len_q) state_nxt = ST_IDLE;
            end
         end
`endif

         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi4_mst_bridge.sv
// Directed bench for axi4_mst_bridge: the bench plays the AXI slave by hand.
// Latency: n/a. Backpressure: exercised through i_resp_ready and wready.
// Covers reset, single read, throttled read burst, gappy write burst,
// SLVERR write, mid-burst reset and, when compiled in, the 4 KB check.
module tb_axi4_mst_bridge;
   import axi4_mst_bridge_pkg::*;

   logic                              i_clk;
   logic                              i_nrst;
   dev_config_type                    o_cfg;
   axi4_master_in_type                xin;
   axi4_master_out_type               xout;
   logic                              i_req_valid;
   logic                              o_req_ready;
   logic                              i_req_write;
   logic [CFG_SYSBUS_ADDR_BITS-1:0]   i_req_addr;
   logic [7:0]                        i_req_len;
   logic                              i_wvalid;
   logic                              o_wready;
   logic [CFG_SYSBUS_DATA_BITS-1:0]   i_wdata;
   logic [CFG_SYSBUS_DATA_BYTES-1:0]  i_wstrb;
   logic                              o_resp_valid;
   logic                              i_resp_ready;
   logic [CFG_SYSBUS_DATA_BITS-1:0]   o_resp_rdata;
   logic                              o_resp_last;
   logic                              o_resp_err;

   int checks   = 0;
   int failures = 0;
   int beat;
   int wl_cnt;

   axi4_mst_bridge dut (
      .i_clk        (i_clk),
      .i_nrst       (i_nrst),
      .o_cfg        (o_cfg),
      .i_xmsti      (xin),
      .o_xmsto      (xout),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_write  (i_req_write),
      .i_req_addr   (i_req_addr),
      .i_req_len    (i_req_len),
      .i_wvalid     (i_wvalid),
      .o_wready     (o_wready),
      .i_wdata      (i_wdata),
      .i_wstrb      (i_wstrb),
      .o_resp_valid (o_resp_valid),
      .i_resp_ready (i_resp_ready),
      .o_resp_rdata (o_resp_rdata),
      .o_resp_last  (o_resp_last),
      .o_resp_err   (o_resp_err)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic request(input logic wr, input logic [31:0] addr, input logic [7:0] len);
      i_req_valid = 1'b1;
      i_req_write = wr;
      i_req_addr  = addr;
      i_req_len   = len;
      #1;
      chk("req_ready_idle", 64'(o_req_ready), 64'd1);
      tick();
      i_req_valid = 1'b0;
      #1;
      chk("req_ready_busy", 64'(o_req_ready), 64'd0);
   endtask

   initial begin
      i_nrst       = 1'b0;
      xin          = '0;
      i_req_valid  = 1'b0;
      i_req_write  = 1'b0;
      i_req_addr   = '0;
      i_req_len    = '0;
      i_wvalid     = 1'b0;
      i_wdata      = '0;
      i_wstrb      = '0;
      i_resp_ready = 1'b0;

      // ---------------- reset state
      tick(); tick(); tick();
      chk("rst_req_ready", 64'(o_req_ready), 64'd1);
      chk("rst_ar_valid",  64'(xout.ar_valid), 64'd0);
      chk("rst_aw_valid",  64'(xout.aw_valid), 64'd0);
      chk("rst_w_valid",   64'(xout.w_valid), 64'd0);
      chk("rst_b_ready",   64'(xout.b_ready), 64'd0);
      chk("rst_r_ready",   64'(xout.r_ready), 64'd0);
      chk("rst_wready",    64'(o_wready), 64'd0);
      chk("rst_resp_vld",  64'(o_resp_valid), 64'd0);
      chk("rst_rdata",     64'(o_resp_rdata), 64'd0);
      chk("rst_resp_last", 64'(o_resp_last), 64'd0);
      chk("rst_resp_err",  64'(o_resp_err), 64'd0);
      chk("cfg_vid",       64'(o_cfg.vid), 64'h00F1);
      chk("cfg_did",       64'(o_cfg.did), 64'h0);
      i_nrst = 1'b1;
      tick();

      // ---------------- single read, len 0
      request(1'b0, 32'h0000_1000, 8'd0);
      chk("rd1_ar_valid", 64'(xout.ar_valid), 64'd1);
      chk("rd1_ar_addr",  64'(xout.ar_addr), 64'h1000);
      chk("rd1_ar_len",   64'(xout.ar_len), 64'd0);
      chk("rd1_ar_size",  64'(xout.ar_size), 64'd3);
      chk("rd1_ar_burst", 64'(xout.ar_burst), 64'd1);
      chk("rd1_ar_id",    64'(xout.ar_id), 64'd0);
      chk("rd1_aw_valid", 64'(xout.aw_valid), 64'd0);
      xin.ar_ready = 1'b1;
      tick();
      xin.ar_ready = 1'b0;
      xin.r_valid  = 1'b1;
      xin.r_data   = 64'hDEADBEEF_00000001;
      xin.r_last   = 1'b1;
      xin.r_resp   = AXI_RESP_OKAY;
      i_resp_ready = 1'b1;
      #1;
      chk("rd1_ar_dropped", 64'(xout.ar_valid), 64'd0);
      chk("rd1_resp_vld",   64'(o_resp_valid), 64'd1);
      chk("rd1_rdata",      64'(o_resp_rdata), 64'hDEADBEEF_00000001);
      chk("rd1_last",       64'(o_resp_last), 64'd1);
      chk("rd1_err",        64'(o_resp_err), 64'd0);
      chk("rd1_rready",     64'(xout.r_ready), 64'd1);
      chk("rd1_no_accept",  64'(o_req_ready), 64'd0);
      tick();
      xin.r_valid = 1'b0;
      #1;
      chk("rd1_idle", 64'(o_req_ready), 64'd1);

      // ---------------- read burst len 3, consumer ready toggles
      request(1'b0, 32'h0000_2000, 8'd3);
      chk("rb_ar_len", 64'(xout.ar_len), 64'd3);
      xin.ar_ready = 1'b1;
      tick();
      xin.ar_ready = 1'b0;
      beat = 0;
      for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
         i_resp_ready = (cyc % 2 == 1);
         xin.r_valid  = 1'b1;
         xin.r_data   = 64'h1111_0000_0000_0000 + 64'(beat);
         xin.r_last   = (beat == 3);
         xin.r_resp   = AXI_RESP_OKAY;
         #1;
         chk("rb_rready_mirror", 64'(xout.r_ready), 64'(i_resp_ready));
         chk("rb_resp_vld", 64'(o_resp_valid), 64'd1);
         if (i_resp_ready) begin
            chk("rb_rdata", 64'(o_resp_rdata), 64'h1111_0000_0000_0000 + 64'(beat));
            chk("rb_last",  64'(o_resp_last), 64'(beat == 3));
            beat++;
         end
         tick();
      end
      xin.r_valid  = 1'b0;
      i_resp_ready = 1'b0;
      #1;
      chk("rb_beats", 64'(beat), 64'd4);
      chk("rb_idle",  64'(o_req_ready), 64'd1);

      // ---------------- write burst len 7, AW held off 5 cycles, W gaps
      request(1'b1, 32'h0000_3000, 8'd7);
      for (int d = 0; d < 5; d++) begin
         chk("wb_aw_hold_vld",  64'(xout.aw_valid), 64'd1);
         chk("wb_aw_hold_addr", 64'(xout.aw_addr), 64'h3000);
         tick();
      end
      chk("wb_aw_len",   64'(xout.aw_len), 64'd7);
      chk("wb_aw_size",  64'(xout.aw_size), 64'd3);
      chk("wb_aw_burst", 64'(xout.aw_burst), 64'd1);
      chk("wb_aw_id",    64'(xout.aw_id), 64'd0);
      xin.aw_ready = 1'b1;
      tick();
      xin.aw_ready = 1'b0;
      xin.w_ready  = 1'b1;
      beat   = 0;
      wl_cnt = 0;
      for (int cyc = 0; cyc < 40 && beat < 8; cyc++) begin
         i_wvalid = (cyc % 3 != 1);
         i_wdata  = 64'hC0DE_0000_0000_0000 + 64'(beat);
         i_wstrb  = 8'hF0 ^ 8'(beat);
         #1;
         chk("wb_wvalid_pass", 64'(xout.w_valid), 64'(i_wvalid));
         chk("wb_wready",      64'(o_wready), 64'd1);
         if (i_wvalid) begin
            chk("wb_wdata", 64'(xout.w_data), 64'hC0DE_0000_0000_0000 + 64'(beat));
            chk("wb_wstrb", 64'(xout.w_strb), 64'(8'hF0 ^ 8'(beat)));
            chk("wb_wlast", 64'(xout.w_last), 64'(beat == 7));
            if (xout.w_last) wl_cnt++;
            beat++;
         end
         tick();
      end
      i_wvalid = 1'b0;
      #1;
      chk("wb_beats",     64'(beat), 64'd8);
      chk("wb_wlast_cnt", 64'(wl_cnt), 64'd1);
      chk("wb_b_wait_vld", 64'(o_resp_valid), 64'd0);
      chk("wb_b_wready",   64'(o_wready), 64'd0);
      xin.b_valid  = 1'b1;
      xin.b_resp   = AXI_RESP_OKAY;
      i_resp_ready = 1'b1;
      #1;
      chk("wb_b_ready", 64'(xout.b_ready), 64'd1);
      chk("wb_cmp_vld", 64'(o_resp_valid), 64'd1);
      chk("wb_cmp_last", 64'(o_resp_last), 64'd1);
      chk("wb_cmp_err", 64'(o_resp_err), 64'd0);
      chk("wb_cmp_rdata", 64'(o_resp_rdata), 64'd0);
      tick();
      xin.b_valid  = 1'b0;
      i_resp_ready = 1'b0;
      #1;
      chk("wb_idle", 64'(o_req_ready), 64'd1);

      // ---------------- single write answered with SLVERR
      request(1'b1, 32'h0000_4008, 8'd0);
      xin.aw_ready = 1'b1;
      tick();
      xin.aw_ready = 1'b0;
      i_wvalid = 1'b1;
      i_wdata  = 64'h0123_4567_89AB_CDEF;
      i_wstrb  = 8'h0F;
      #1;
      chk("se_wlast", 64'(xout.w_last), 64'd1);
      tick();
      i_wvalid     = 1'b0;
      xin.b_valid  = 1'b1;
      xin.b_resp   = AXI_RESP_SLVERR;
      i_resp_ready = 1'b1;
      #1;
      chk("se_vld",  64'(o_resp_valid), 64'd1);
      chk("se_err",  64'(o_resp_err), 64'd1);
      chk("se_last", 64'(o_resp_last), 64'd1);
      tick();
      xin.b_valid  = 1'b0;
      i_resp_ready = 1'b0;
      #1;
      chk("se_idle", 64'(o_req_ready), 64'd1);

      // ---------------- reset asserted during W beat 3
      request(1'b1, 32'h0000_5000, 8'd7);
      xin.aw_ready = 1'b1;
      tick();
      xin.aw_ready = 1'b0;
      i_wvalid     = 1'b1;
      for (int b = 0; b < 3; b++) begin
         i_wdata = 64'(b);
         tick();
      end
      i_wdata = 64'd3;
      #1;
      chk("rs_w_active", 64'(xout.w_valid), 64'd1);
      chk("rs_w_not_last", 64'(xout.w_last), 64'd0);
      i_nrst = 1'b0;
      #1;
      chk("rs_w_valid",  64'(xout.w_valid), 64'd0);
      chk("rs_aw_valid", 64'(xout.aw_valid), 64'd0);
      chk("rs_ar_valid", 64'(xout.ar_valid), 64'd0);
      chk("rs_wready",   64'(o_wready), 64'd0);
      chk("rs_resp_vld", 64'(o_resp_valid), 64'd0);
      tick();
      i_nrst   = 1'b1;
      i_wvalid = 1'b0;
      xin.w_ready = 1'b0;
      tick();
      chk("rs_req_ready", 64'(o_req_ready), 64'd1);
      chk("rs_w_idle",    64'(xout.w_valid), 64'd0);

`ifdef AXI4_MST_BRIDGE_4K_CHECK_EN
      // ---------------- read crossing a 4 KB page: local error beats
      request(1'b0, 32'h0000_0FF8, 8'd1);
      i_resp_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         #1;
         chk("k4_no_ar",   64'(xout.ar_valid), 64'd0);
         chk("k4_vld",     64'(o_resp_valid), 64'd1);
         chk("k4_err",     64'(o_resp_err), 64'd1);
         chk("k4_rdata",   64'(o_resp_rdata), 64'd0);
         chk("k4_last",    64'(o_resp_last), 64'(b == 1));
         tick();
      end
      i_resp_ready = 1'b0;
      #1;
      chk("k4_idle", 64'(o_req_ready), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
